// File: rtl/solar_adc_scheduler_pkg.sv
// solar_pkg: shared types and constants for the solar monitor ADC scheduler.
//   state_t    - scheduler FSM states
//   ADC_*      - MCP3008-style frame geometry
//   adc_cmd()  - 5-bit command word {START, SGL, ch}
//   first_set()- lowest set mask bit at or above an index; bit 3 set = none
package solar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        NEXT
    } state_t;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_BITS  = 10;
    localparam int ADC_CMD_BITS   = 5;

    localparam logic ADC_START = 1'b1;
    localparam logic ADC_SGL   = 1'b1;   // single-ended conversion

    function automatic logic [ADC_CMD_BITS-1:0] adc_cmd(input logic [2:0] ch);
        return {ADC_START, ADC_SGL, ch};
    endfunction

    // Scans downward so the last hit is the lowest qualifying index.
    function automatic logic [3:0] first_set(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && i >= int'(from)) r = {1'b0, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/solar_adc_scheduler_if.sv
// solar_adc_scheduler_if: ADC pin bundle plus the tagged-sample output bus.
//   master: scheduler side (drives SPI pins and sample/status outputs)
//   slave : pad/monitor side (drives adc_miso_i)
interface solar_adc_scheduler_if;
    import solar_pkg::*;

    logic                     adc_cs_n_o;
    logic                     adc_sclk_o;
    logic                     adc_mosi_o;
    logic                     adc_miso_i;
    logic                     sample_valid_o;
    logic [2:0]               sample_ch_o;
    logic [ADC_DATA_BITS-1:0] sample_data_o;
    logic                     scan_done_o;
    logic                     busy_o;
    logic                     overrun_o;

    modport master (
        output adc_cs_n_o, adc_sclk_o, adc_mosi_o,
        output sample_valid_o, sample_ch_o, sample_data_o,
        output scan_done_o, busy_o, overrun_o,
        input  adc_miso_i
    );

    modport slave (
        input  adc_cs_n_o, adc_sclk_o, adc_mosi_o,
        input  sample_valid_o, sample_ch_o, sample_data_o,
        input  scan_done_o, busy_o, overrun_o,
        output adc_miso_i
    );

endinterface

// File: rtl/solar_adc_scheduler_spi_adc_frame.sv
// spi_adc_frame: one 16-period SPI frame (SCLK idle low, CS handled by caller).
//   start : pulse in the last CS setup cycle; SCLK low phase of period 0 follows
//   abort : forces SCLK/MOSI low and stops the frame on the next edge
//   ch    : channel encoded into the command bits
//   done  : high during the final cycle of period 15 (combinational)
//   data  : 10-bit result, MSB first from periods 6..15
module spi_adc_frame
    import solar_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2:0]               ch,
    input  logic                     miso,
    output logic                     sclk,
    output logic                     mosi,
    output logic                     done,
    output logic [ADC_DATA_BITS-1:0] data
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HALVES = 2 * ADC_FRAME_BITS;
    localparam int HALF_W = $clog2(HALVES);
    localparam logic [HALF_W-2:0] FIRST_DATA_PER = (HALF_W-1)'(ADC_FRAME_BITS - ADC_DATA_BITS);

    logic                    active;
    logic [DIV_W-1:0]        div_cnt;
    logic [HALF_W-1:0]       half;      // even = SCLK low phase, odd = high phase
    logic [ADC_CMD_BITS-1:0] cmd_sr;
    logic [ADC_CMD_BITS-1:0] cmd_w;
    logic                    last_div;

    assign cmd_w    = adc_cmd(ch);
    assign last_div = div_cnt == DIV_W'(CLK_DIV - 1);
    assign done     = active && last_div && half == HALF_W'(HALVES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            half    <= '0;
            cmd_sr  <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            data    <= '0;
        end else if (abort) begin
            active  <= 1'b0;
            div_cnt <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            mosi    <= cmd_w[ADC_CMD_BITS-1];
            cmd_sr  <= {cmd_w[ADC_CMD_BITS-2:0], 1'b0};
        end else if (active) begin
            if (last_div) begin
                div_cnt <= '0;
                half    <= half + 1'b1;
                if (done) begin
                    active <= 1'b0;
                    sclk   <= 1'b0;
                    mosi   <= 1'b0;
                end else if (!half[0]) begin
                    // rising edge: capture MISO only in the data periods
                    sclk <= 1'b1;
                    if (half[HALF_W-1:1] >= FIRST_DATA_PER)
                        data <= {data[ADC_DATA_BITS-2:0], miso};
                end else begin
                    // falling edge: next command bit; shifter drains to 0 after bit 4
                    sclk   <= 1'b0;
                    mosi   <= cmd_sr[ADC_CMD_BITS-1];
                    cmd_sr <= {cmd_sr[ADC_CMD_BITS-2:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/solar_adc_scheduler.sv
// solar_adc_scheduler: periodic scan controller for an 8-channel SPI ADC.
//   wb_clk_i   : clock
//   wb_rst_n_i : async active-low reset
//   enable_i   : run periodic scans; low aborts any scan and clears overrun
//   ch_mask_i  : channel enables, latched at scan start
//   adc        : SPI pins and sample/scan_done/busy/overrun outputs (master)
module solar_adc_scheduler
    import solar_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 4,
    parameter int PERIOD  = 1000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 enable_i,
    input  logic [NUM_CH-1:0]    ch_mask_i,
    solar_adc_scheduler_if.master adc
);

    localparam int PER_W = $clog2(PERIOD);
    localparam int TMR_W = $clog2(2 * CLK_DIV);

    logic [PER_W-1:0]         per_cnt;
    logic                     tick;
    state_t                   state;
    logic [TMR_W-1:0]         tmr;
    logic [7:0]               mask_in;
    logic [7:0]               mask_q;
    logic [2:0]               cur_ch;
    logic [3:0]               first_ch;
    logic [3:0]               next_ch;
    logic                     cs_n_q, valid_q, done_q, busy_q, ovr_q;
    logic [2:0]               s_ch_q;
    logic [ADC_DATA_BITS-1:0] s_data_q;
    logic                     frame_start, frame_done, sclk, mosi;
    logic [ADC_DATA_BITS-1:0] frame_data;

    assign tick        = enable_i && per_cnt == '0;
    assign mask_in     = 8'(ch_mask_i);
    assign first_ch    = first_set(mask_in, 4'd0);
    assign next_ch     = first_set(mask_q, {1'b0, cur_ch} + 4'd1);
    assign frame_start = enable_i && state == CS_SETUP && tmr == TMR_W'(CLK_DIV - 1);

    // Free-running scan period; parked at 0 so enabling ticks immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)                           per_cnt <= '0;
        else if (!enable_i)                        per_cnt <= '0;
        else if (per_cnt == PER_W'(PERIOD - 1))    per_cnt <= '0;
        else                                       per_cnt <= per_cnt + 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            tmr      <= '0;
            mask_q   <= '0;
            cur_ch   <= '0;
            cs_n_q   <= 1'b1;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            s_ch_q   <= '0;
            s_data_q <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (!enable_i) begin
                // abort wins over any sample/done that would fire this edge
                state  <= IDLE;
                cs_n_q <= 1'b1;
                busy_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                if (tick && state != IDLE) ovr_q <= 1'b1;
                case (state)
                    IDLE: if (tick) begin
                        mask_q <= mask_in;
                        if (first_ch[3]) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            cur_ch <= first_ch[2:0];
                            cs_n_q <= 1'b0;
                            tmr    <= '0;
                            state  <= CS_SETUP;
                        end
                    end
                    CS_SETUP: begin
                        tmr <= tmr + 1'b1;
                        if (frame_start) state <= SHIFT;
                    end
                    SHIFT: if (frame_done) begin
                        state    <= CS_HOLD;
                        cs_n_q   <= 1'b1;
                        tmr      <= '0;
                        valid_q  <= 1'b1;
                        s_ch_q   <= cur_ch;
                        s_data_q <= frame_data;
                    end
                    CS_HOLD: begin
                        tmr <= tmr + 1'b1;
                        if (tmr == TMR_W'(2 * CLK_DIV - 1)) state <= NEXT;
                    end
                    NEXT: if (next_ch[3]) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cur_ch <= next_ch[2:0];
                        cs_n_q <= 1'b0;
                        tmr    <= '0;
                        state  <= CS_SETUP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_adc_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .start (frame_start),
        .abort (!enable_i),
        .ch    (cur_ch),
        .miso  (adc.adc_miso_i),
        .sclk  (sclk),
        .mosi  (mosi),
        .done  (frame_done),
        .data  (frame_data)
    );

    assign adc.adc_cs_n_o     = cs_n_q;
    assign adc.adc_sclk_o     = sclk;
    assign adc.adc_mosi_o     = mosi;
    assign adc.sample_valid_o = valid_q;
    assign adc.sample_ch_o    = s_ch_q;
    assign adc.sample_data_o  = s_data_q;
    assign adc.scan_done_o    = done_q;
    assign adc.busy_o         = busy_q;
    assign adc.overrun_o      = ovr_q;

endmodule

// File: tb/tb_solar_adc_scheduler.sv
// tb_solar_adc_scheduler: directed scans against an MCP3008-style ADC model.
// Expected samples, scan_done cycles and command words are queued when a scan
// is launched; negedge monitors pop and compare as the DUT produces them.
module tb_solar_adc_scheduler;

    localparam int CD       = 4;
    localparam int PER      = 300;
    localparam int SV_OFS   = 1 + 33 * CD;    // tick -> first sample_valid
    localparam int FRAME    = 35 * CD + 1;    // sample spacing within a scan
    localparam int HOLD_OFS = 2 * CD + 1;     // last sample -> scan_done

    typedef struct {
        int ch;
        int data;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] mask = 4'b0;
    logic       miso = 1'b0;
    bit         mode = 1'b0;     // 0: ADC returns 0x2A5, 1: 100*ch+5
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t_scan = 0;
    int         cs_falls = 0;

    exp_t       sq[$];
    int         dq[$];
    logic [4:0] cq[$];

    solar_adc_scheduler_if bus();
    assign bus.adc_miso_i = miso;

    solar_adc_scheduler #(.NUM_CH(4), .CLK_DIV(CD), .PERIOD(PER)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .enable_i   (enable),
        .ch_mask_i  (mask),
        .adc        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    // Queue expectations for a scan ticking at t0; only the first nlim
    // frames complete, and scan_done is expected only if all of them do.
    task automatic push_scan(input logic [3:0] m, input int t0, input int nlim);
        int   k;
        exp_t s;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                if (k < nlim) begin
                    s.ch   = c;
                    s.data = mode ? 100 * c + 5 : 'h2A5;
                    s.cyc  = t0 + SV_OFS + k * FRAME;
                    sq.push_back(s);
                    cq.push_back({2'b11, 3'(c)});
                end
                k++;
            end
        end
        if (k <= nlim) dq.push_back(k == 0 ? t0 + 1 : t0 + SV_OFS + (k - 1) * FRAME + HOLD_OFS);
    endtask

    task automatic start_scan(input logic [3:0] m, input int nlim);
        mask   = m;
        enable = 1'b1;
        t_scan = cyc;
        push_scan(m, t_scan, nlim);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cs_n"},   int'(bus.adc_cs_n_o), 1);
        chk({tag, "_sclk"},   int'(bus.adc_sclk_o), 0);
        chk({tag, "_mosi"},   int'(bus.adc_mosi_o), 0);
        chk({tag, "_valid"},  int'(bus.sample_valid_o), 0);
        chk({tag, "_ch"},     int'(bus.sample_ch_o), 0);
        chk({tag, "_data"},   int'(bus.sample_data_o), 0);
        chk({tag, "_done"},   int'(bus.scan_done_o), 0);
        chk({tag, "_busy"},   int'(bus.busy_o), 0);
        chk({tag, "_ovr"},    int'(bus.overrun_o), 0);
    endtask

    // ADC model: decodes command bits on SCLK rises, returns data MSB first.
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;
    int         rises = 0;
    int         cs_len = 0;
    int         mosi_bad = 0;
    logic [4:0] cmd_bits = 5'b0;
    logic [9:0] mval = 10'b0;
    logic [4:0] ecmd;

    always @(negedge clk) begin
        if (!bus.adc_cs_n_o) cs_len++;
        if (!bus.adc_cs_n_o && prev_cs) cs_falls++;
        if (bus.adc_sclk_o && !prev_sclk) begin
            if (rises < 5) cmd_bits = {cmd_bits[3:0], bus.adc_mosi_o};
            else if (bus.adc_mosi_o) mosi_bad = 1;
            if (rises == 5) mval = mode ? 10'(100 * int'(cmd_bits[2:0]) + 5) : 10'h2A5;
            if (rises >= 5 && rises <= 14) miso = mval[4'(14 - rises)];
            rises++;
        end
        if (bus.adc_cs_n_o && !prev_cs) begin
            if (rises == 16 && cq.size() > 0) begin
                ecmd = cq.pop_front();
                chk("mosi_cmd", int'(cmd_bits), int'(ecmd));
                chk("cs_low_len", cs_len, 33 * CD);
                chk("mosi_tail_zero", mosi_bad, 0);
            end
            rises    = 0;
            cs_len   = 0;
            mosi_bad = 0;
            miso     = 1'b0;
        end
        prev_sclk = bus.adc_sclk_o;
        prev_cs   = bus.adc_cs_n_o;
    end

    // Output monitor
    exp_t s_m;
    int   d_m;
    always @(negedge clk) begin
        if (bus.sample_valid_o) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: ch %0d data %0d at cycle %0d, expected none",
                         bus.sample_ch_o, bus.sample_data_o, cyc);
            end else begin
                s_m = sq.pop_front();
                chk("sample_ch", int'(bus.sample_ch_o), s_m.ch);
                chk("sample_data", int'(bus.sample_data_o), s_m.data);
                chk("sample_cycle", cyc, s_m.cyc);
            end
        end
        if (bus.scan_done_o) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_scan_done: at cycle %0d, expected none", cyc);
            end else begin
                d_m = dq.pop_front();
                chk("scan_done_cycle", cyc, d_m);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0;
    int fc;

    initial begin
        step(2);
        check_reset_state("reset");
        rst_n = 1'b1;
        step(3);

        // single channel, fixed data 0x2A5
        mode = 1'b0;
        start_scan(4'b0001, 8);
        goto(t_scan + 200);
        enable = 1'b0;
        step(5);

        // all channels with PERIOD < scan length: overrun, dropped tick, abort
        mode = 1'b1;
        start_scan(4'b1111, 8);
        t0 = t_scan;
        goto(t0 + PER);
        chk("ovr_before_tick", int'(bus.overrun_o), 0);
        step(1);
        chk("ovr_after_tick", int'(bus.overrun_o), 1);
        push_scan(4'b1111, t0 + 2 * PER, 2);
        goto(t0 + 2 * PER);
        chk("scan2_cs_idle", int'(bus.adc_cs_n_o), 1);
        step(1);
        chk("scan2_cs_fall", int'(bus.adc_cs_n_o), 0);
        chk("scan2_busy", int'(bus.busy_o), 1);
        goto(t0 + 2 * PER + 295);
        chk("pre_abort_cs", int'(bus.adc_cs_n_o), 0);
        chk("pre_abort_ovr", int'(bus.overrun_o), 1);
        enable = 1'b0;
        step(1);
        chk("abort_cs_n", int'(bus.adc_cs_n_o), 1);
        chk("abort_sclk", int'(bus.adc_sclk_o), 0);
        chk("abort_mosi", int'(bus.adc_mosi_o), 0);
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_ovr_clear", int'(bus.overrun_o), 0);
        step(200);

        // re-enable: fresh scan from channel 0
        start_scan(4'b1111, 8);
        goto(t_scan + 580);
        enable = 1'b0;
        step(5);

        // sparse mask
        start_scan(4'b1010, 8);
        goto(t_scan + 290);
        enable = 1'b0;
        step(3);

        // empty mask: immediate scan_done, CS never falls
        fc = cs_falls;
        start_scan(4'b0000, 8);
        goto(t_scan + 20);
        chk("empty_no_cs", cs_falls, fc);
        enable = 1'b0;
        step(3);

        // asynchronous reset mid-frame
        start_scan(4'b1111, 0);
        goto(t_scan + 50);
        chk("pre_reset_cs", int'(bus.adc_cs_n_o), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);

        chk("pending_samples", sq.size(), 0);
        chk("pending_scan_done", dq.size(), 0);
        chk("pending_cmds", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
